apb_to_fll_multi: RTL
=====================

// Module: apb_to_fll_multi
// PURPOSE
// APB slave bridging one APB port to NB_FLL FLL configuration interfaces (req/ack 4-phase, async ack).
// Successor of the single-interface APB-to-FLL bridge: N targets decoded from paddr,
// registered read data, ack-timeout with PSLVERR, PSLVERR on out-of-range target.
// Sits in the SoC control peripheral cluster, between the APB demux and the FLL instances.
// PARAMETERS
// APB_ADDR_WIDTH  12  APB address width
// NB_FLL          4   number of FLL targets (1..8)
// FLL_ADDR_WIDTH  4   FLL register address width
// SYNC_STAGES     2   ack synchroniser depth (>=2)
// TIMEOUT_CYCLES  1023  clk_i cycles waiting for ack before error; 0 = no timeout
// PORTS
// clk_i          in   1                    APB clock
// rst_ni         in   1                    async reset, active low
// apb_paddr_i    in   APB_ADDR_WIDTH       [FLL_ADDR_WIDTH+1:2]=reg, next $clog2(NB_FLL) bits (min 1)=target
// apb_pwdata_i   in   32                   write data
// apb_pwrite_i   in   1                    1=write
// apb_psel_i     in   1                    select
// apb_penable_i  in   1                    access phase
// apb_prdata_o   out  32                   read data (registered)
// apb_pready_o   out  1                    transfer done
// apb_pslverr_o  out  1                    error (bad target / timeout)
// fll_req_o      out  NB_FLL               one-hot request
// fll_wen_o      out  1                    active-low write enable (1=read)
// fll_addr_o     out  FLL_ADDR_WIDTH       register address
// fll_wdata_o    out  32                   write data
// fll_rdata_i    in   NB_FLL x 32          per-target read data, stable while its ack=1
// fll_ack_i      in   NB_FLL               per-target ack, async to clk_i
// BEHAVIOUR
// Reset: state IDLE; all outputs 0 except fll_wen_o=1; captured regs and timeout counter 0.
// fll_addr_o/fll_wdata_o/fll_wen_o come from registers captured in IDLE; held stable REQ..WAIT_LOW.
// Each fll_ack_i synchronised by SYNC_STAGES flops; only the selected target's ack_s is used.
// FSM:
//  IDLE: psel&penable -> capture addr/wdata/write/target; target>=NB_FLL -> ERR, else REQ.
//  REQ: fll_req_o[tgt]=1, cnt++. ack_s=1 -> latch rdata (reads only), go RESP.
//       TIMEOUT_CYCLES!=0 && cnt==TIMEOUT_CYCLES-1 -> drop req, go TOUT.
//  RESP: pready=1, pslverr=0, prdata=latched (0 for writes) for exactly 1 cycle -> WAIT_LOW.
//  TOUT: pready=1, pslverr=1, prdata=0 for 1 cycle -> WAIT_LOW.
//  ERR: pready=1, pslverr=1, prdata=0 for 1 cycle, no fll_req_o -> IDLE.
//  WAIT_LOW: req=0; selected ack_s=0 -> IDLE (pready=0 meanwhile).
// pready, pslverr, prdata registered from state; 0/0/0 outside RESP/TOUT/ERR.
// Latency (valid target, ack raw at cycle Ta): pready at Ta+SYNC_STAGES+1; min 4 clk from penable.
// Back-to-back: next transfer waits (pready=0) until previous FSM returns to IDLE.
// Late ack after timeout: absorbed in WAIT_LOW; its data discarded; no second pready.
// psel dropped mid-transfer (protocol violation): FSM still completes handshake; pready pulse ignored.
// Only one fll_req_o bit ever high; req never reasserted before selected ack_s seen low.
// Reset mid-transfer: req drops asynchronously; FLL side resolves its own 4-phase on reset.
// STRUCTURE
// apb_fll_pkg: state enum (IDLE,REQ,RESP,TOUT,ERR,WAIT_LOW), FLL_DATA_WIDTH=32, TGT_W function.
// Sub-module fll_ack_sync (SYNC_STAGES flop chain, async reset), one instance per target.
// Timeout counter width $clog2(TIMEOUT_CYCLES+1); omitted via generate when TIMEOUT_CYCLES=0.
// TESTING
// 1 Write tgt 2 reg 5 data 0xCAFE0001, ack after 3 clk -> fll_req_o=4'b0100, addr 5, wen 0; pready, pslverr 0.
// 2 Read tgt 0 reg 3, rdata0=0x12345678 with ack -> prdata 0x12345678, pslverr 0.
// 3 Access target index 5 with NB_FLL=4 -> ERR: pready+pslverr 2 clk after penable, fll_req_o stays 0.
// 4 TIMEOUT_CYCLES=16, no ack -> req high 16 clk, pready+pslverr=1, prdata 0; later ack ignored.
// 5 Two back-to-back writes tgt 1 then 3, ack held 10 clk -> second req only after ack1 synced low.
// 6 Assert rst_ni low during REQ -> fll_req_o=0 immediately, FSM IDLE, next read completes normally.

Source files
------------

// File: rtl/apb_fll_pkg.sv
// Shared types and helpers for the multi-target APB-to-FLL bridge.
// Holds the FSM state encoding and the target-index width function.
package apb_fll_pkg;

    localparam int FLL_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        TOUT,
        ERR,
        WAIT_LOW
    } state_e;

    function automatic int TGT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_to_fll_multi_sync.sv
// Multi-flop synchroniser for one asynchronous FLL acknowledge line.
// Module fll_ack_sync; one instance per FLL target.
module fll_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ack_i,
    output logic ack_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ack_i};
        end
    end

    assign ack_o = sync_q[STAGES-1];

endmodule

// File: rtl/apb_to_fll_multi.sv
// APB slave bridging one APB port to NB_FLL FLL configuration ports
// using a 4-phase req/ack handshake with ack timeout and PSLVERR.
module apb_to_fll_multi
    import apb_fll_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_FLL         = 4,
    parameter int FLL_ADDR_WIDTH = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]              apb_paddr_i,
    input  logic [FLL_DATA_WIDTH-1:0]              apb_pwdata_i,
    input  logic                                   apb_pwrite_i,
    input  logic                                   apb_psel_i,
    input  logic                                   apb_penable_i,
    output logic [FLL_DATA_WIDTH-1:0]              apb_prdata_o,
    output logic                                   apb_pready_o,
    output logic                                   apb_pslverr_o,
    output logic [NB_FLL-1:0]                      fll_req_o,
    output logic                                   fll_wen_o,
    output logic [FLL_ADDR_WIDTH-1:0]              fll_addr_o,
    output logic [FLL_DATA_WIDTH-1:0]              fll_wdata_o,
    input  logic [NB_FLL-1:0][FLL_DATA_WIDTH-1:0]  fll_rdata_i,
    input  logic [NB_FLL-1:0]                      fll_ack_i
);

    localparam int TW = TGT_W(NB_FLL);
    localparam int UW = APB_ADDR_WIDTH - FLL_ADDR_WIDTH - 2;

    state_e                      state_q, state_d;
    logic [FLL_ADDR_WIDTH-1:0]   addr_q;
    logic [FLL_DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [FLL_DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                        wen_q, pready_q, pready_d;
    logic                        pslverr_q, pslverr_d;
    logic [TW-1:0]               tgt_q;
    logic [NB_FLL-1:0]           ack_s, req_vec;
    logic                        sel_ack, timeout, accept, bad_tgt;
    logic [FLL_DATA_WIDTH-1:0]   sel_rdata;
    logic [UW-1:0]               up_addr;
    logic                        unused_paddr;

    // Whole upper address is decoded so unrepresentable indices also error.
    assign up_addr      = apb_paddr_i[APB_ADDR_WIDTH-1:FLL_ADDR_WIDTH+2];
    assign bad_tgt      = 32'(up_addr) >= 32'(NB_FLL);
    assign unused_paddr = ^apb_paddr_i[1:0];

    // pready_q guard stops the completing access from being re-accepted.
    assign accept = (state_q == IDLE) && apb_psel_i &&
                    apb_penable_i && !pready_q;

    for (genvar i = 0; i < NB_FLL; i++) begin : g_sync
        fll_ack_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .ack_i (fll_ack_i[i]),
            .ack_o (ack_s[i])
        );
    end

    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        req_vec   = '0;
        for (int i = 0; i < NB_FLL; i++) begin
            if (tgt_q == TW'(i)) begin
                sel_ack    = ack_s[i];
                sel_rdata  = fll_rdata_i[i];
                req_vec[i] = 1'b1;
            end
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_tout
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end

        assign timeout = (state_q == REQ) &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tout
        assign timeout = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        unique case (state_q)
            IDLE:     if (accept) state_d = bad_tgt ? ERR : REQ;
            REQ: begin
                if (sel_ack) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = TOUT;
                end
            end
            RESP: begin
                state_d  = WAIT_LOW;
                pready_d = 1'b1;
                prdata_d = rdata_q;
            end
            TOUT: begin
                state_d   = WAIT_LOW;
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
            end
            ERR: begin
                state_d   = IDLE;
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
            end
            WAIT_LOW: if (!sel_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b1;
            tgt_q     <= '0;
            rdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (accept) begin
                addr_q  <= apb_paddr_i[FLL_ADDR_WIDTH+1:2];
                wdata_q <= apb_pwdata_i;
                wen_q   <= ~apb_pwrite_i;
                tgt_q   <= up_addr[TW-1:0];
            end
            if (state_q == REQ && sel_ack) begin
                rdata_q <= wen_q ? sel_rdata : '0;
            end
        end
    end

    assign fll_req_o     = (state_q == REQ) ? req_vec : '0;
    assign fll_wen_o     = wen_q;
    assign fll_addr_o    = addr_q;
    assign fll_wdata_o   = wdata_q;
    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;
    assign apb_prdata_o  = prdata_q;

endmodule
